// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : Shared constants and loader state encoding for imem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          LEN_W     = 16;

    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        DONE   = 3'd3,
        ERROR  = 3'd4
    } imem_state_t;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// ============================================================================
// Module      : imem_ram
// Description : Word RAM with one write port and a registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    // Contents are deliberately left out of reset so this maps onto block RAM.
    logic [31:0] r_mem [0:c_DEPTH-1];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        r_rdata <= r_mem[raddr];
    end

    assign rdata = r_rdata;

endmodule : imem_ram
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Length-prefixed byte-stream loader into instruction RAM,
//               serving the core fetch port with a one-cycle registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_pkg::*;
#(
    parameter int          ADDR_W = 10,
    parameter logic [31:0] NOP    = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_data,
    output logic [31:0] last_pc,
    output logic        done,
    output logic        error
);

    localparam logic [31:0] c_DEPTH = 32'(2 ** ADDR_W);

    imem_state_t       r_state;
    imem_state_t       w_state_nxt;

    logic [7:0]        r_len_lo;
    logic [ADDR_W-1:0] r_last_idx;
    logic [ADDR_W-1:0] r_word_idx;
    logic [1:0]        r_byte_cnt;
    logic [31:0]       r_asm;
    logic [31:0]       r_last_pc;
    logic              r_fetch_ok;

    logic              w_accept;
    logic [LEN_W-1:0]  w_len;
    logic [LEN_W-1:0]  w_len_m1;
    logic              w_len_bad;
    logic              w_word_end;
    logic              w_last_word;
    logic [31:0]       w_wdata;
    logic              w_ram_we;
    logic              w_addr_in_range;
    logic [31:0]       w_ram_rdata;

    assign w_accept    = byte_valid && byte_ready;
    assign w_len       = {byte_data, r_len_lo};
    assign w_len_m1    = w_len - 16'd1;
    assign w_len_bad   = (w_len == '0) || ({16'd0, w_len} > c_DEPTH);
    assign w_word_end  = (r_byte_cnt == 2'd3);
    assign w_last_word = (r_word_idx == r_last_idx);
    // Bytes enter at the top and shift down, so the first byte lands in [7:0].
    assign w_wdata     = {byte_data, r_asm[31:8]};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= LEN_LO;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LEN_LO: if (w_accept) w_state_nxt = LEN_HI;
            LEN_HI: if (w_accept) w_state_nxt = w_len_bad ? ERROR : DATA;
            DATA:   if (w_accept && w_word_end && w_last_word) w_state_nxt = DONE;
            DONE:   w_state_nxt = DONE;
            ERROR:  w_state_nxt = ERROR;
            default: w_state_nxt = LEN_LO;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        byte_ready = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        w_ram_we   = 1'b0;
        case (r_state)
            LEN_LO, LEN_HI: byte_ready = 1'b1;
            DATA: begin
                byte_ready = 1'b1;
                w_ram_we   = byte_valid && w_word_end;
            end
            DONE:  done  = 1'b1;
            ERROR: error = 1'b1;
            default: byte_ready = 1'b0;
        endcase
    end

    // ---------------- Loader datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len_lo   <= '0;
            r_last_idx <= '0;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_asm      <= '0;
            r_last_pc  <= '0;
        end else if (w_accept) begin
            case (r_state)
                LEN_LO: r_len_lo <= byte_data;
                LEN_HI: begin
                    r_last_idx <= w_len_m1[ADDR_W-1:0];
                    r_word_idx <= '0;
                    r_byte_cnt <= '0;
                end
                DATA: begin
                    r_asm      <= w_wdata;
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    if (w_word_end) begin
                        if (w_last_word) begin
                            r_last_pc <= {{(32-ADDR_W){1'b0}}, r_last_idx};
                        end else begin
                            r_word_idx <= r_word_idx + ADDR_W'(1);
                        end
                    end
                end
                default: r_len_lo <= r_len_lo;
            endcase
        end
    end

    // ---------------- Fetch gating ----------------
    // done is sampled at the fetch edge, so the first real word follows it by one cycle.
    assign w_addr_in_range = (instr_addr[31:ADDR_W] == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_ok <= 1'b0;
        end else begin
            r_fetch_ok <= done && w_addr_in_range;
        end
    end

    imem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .waddr (r_word_idx),
        .wdata (w_wdata),
        .raddr (instr_addr[ADDR_W-1:0]),
        .rdata (w_ram_rdata)
    );

    assign instr_data = r_fetch_ok ? w_ram_rdata : NOP;
    assign last_pc    = r_last_pc;

endmodule : imem_loader
`default_nettype wire
